muldiv_seq: RTL and testbench

//   Multicycle sequencer for the mult/div resource feeding the HI/LO registers.

---
 rtl/muldiv_seq.sv | 162 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: multicycle radix-2 multiply/divide sequencer feeding HI/LO.
//   Signed shift-add multiply and restoring divide on operand magnitudes.
//   A final FIX cycle applies the result signs.
//   Latency from the start edge to done: WIDTH+2 cycles, or 1 cycle for divide by zero.
// Optional feature: define MULDIV_UNSIGNED_EN to add the op_unsigned input
//   (multu/divu). In that mode the operands are used raw and no sign fix is applied.
// Ports:
//   clk, reset          clock (rising edge); asynchronous active-high reset
//   start, op           request (sampled in IDLE only); op: 0 = div, 1 = mult
//   op_unsigned         (MULDIV_UNSIGNED_EN only) unsigned operation, sampled with start
//   a, b                multiplicand/dividend, multiplier/divisor
//   busy                high from the cycle after acceptance through FIX
//   done                one-cycle pulse; hi/lo are valid in that cycle
//   div_zero            high with done when a divide had b == 0
//   hi, lo              mult: product high/low halves; div: remainder/quotient
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
`ifdef MULDIV_UNSIGNED_EN
  input  logic             op_unsigned,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  logic             op_q, s_lo, s_hi;
  logic [CNT_W-1:0] cnt;
  // hw: product high half / partial remainder
  // lw: multiplier / dividend bits shifting out, with quotient bits shifting in
  // bm: magnitude of the multiplicand (mult) or of the divisor (div)
  logic [WIDTH-1:0] hw, lw, bm;

  logic uns;
`ifdef MULDIV_UNSIGNED_EN
  assign uns = op_unsigned;
`else
  assign uns = 1'b0;
`endif

  logic [WIDTH-1:0] a_mag, b_mag;
  logic             sx;
  assign a_mag = (uns || !a[WIDTH-1]) ? a : -a;
  assign b_mag = (uns || !b[WIDTH-1]) ? b : -b;
  assign sx    = (a[WIDTH-1] ^ b[WIDTH-1]) & ~uns;

  // Multiply step: conditional add, then shift {hw,lw} right by one.
  // The carry out of the add lands in the top bit of hw.
  logic [WIDTH:0] m_sum;
  assign m_sum = {1'b0, hw} + (lw[0] ? {1'b0, bm} : '0);

  // Restoring divide step: shift the next dividend bit into the remainder.
  // Subtract the divisor only if the remainder is large enough.
  logic [WIDTH:0]   r_sh;
  logic             r_ge;
  logic [WIDTH-1:0] r_dif;
  assign r_sh  = {hw, lw[WIDTH-1]};
  assign r_ge  = r_sh >= {1'b0, bm};
  // The difference is below bm, so the low WIDTH bits hold it exactly.
  assign r_dif = r_sh[WIDTH-1:0] - bm;

  logic [2*WIDTH-1:0] prod, prod_fx;
  logic [WIDTH-1:0]   q_fx, r_fx;
  assign prod    = {hw, lw};
  assign prod_fx = s_lo ? -prod : prod;
  assign q_fx    = s_lo ? -lw : lw;
  assign r_fx    = s_hi ? -hw : hw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      op_q     <= 1'b0;
      s_lo     <= 1'b0;
      s_hi     <= 1'b0;
      hw       <= '0;
      lw       <= '0;
      bm       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (!op && b == '0) begin
              // hi/lo keep their previous values
              state    <= DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              cnt   <= CNT_W'(WIDTH);
              op_q  <= op;
              hw    <= '0;
              s_lo  <= sx;
              if (op) begin
                lw   <= b_mag;
                bm   <= a_mag;
                s_hi <= sx;
              end else begin
                lw   <= a_mag;
                bm   <= b_mag;
                s_hi <= a[WIDTH-1] & ~uns;
              end
            end
          end
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (op_q) begin
            hw <= m_sum[WIDTH:1];
            lw <= {m_sum[0], lw[WIDTH-1:1]};
          end else if (r_ge) begin
            hw <= r_dif;
            lw <= {lw[WIDTH-2:0], 1'b1};
          end else begin
            hw <= r_sh[WIDTH-1:0];
            lw <= {lw[WIDTH-2:0], 1'b0};
          end
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          if (op_q) begin
            hi <= prod_fx[2*WIDTH-1:WIDTH];
            lo <= prod_fx[WIDTH-1:0];
          end else begin
            hi <= r_fx;
            lo <= q_fx;
          end
          busy     <= 1'b0;
          done     <= 1'b1;
          div_zero <= 1'b0;
          state    <= DONE;
        end
        DONE: begin
          // A start seen here is dropped; it can be accepted next cycle in IDLE.
          done     <= 1'b0;
          div_zero <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed and random mult/div operations.
// Expected results come from 64-bit arithmetic and go into a scoreboard queue.
// A monitor pops and compares an entry on every done pulse.
module tb_muldiv_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, op;
`ifdef MULDIV_UNSIGNED_EN
  logic         op_unsigned;
`endif
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
`ifdef MULDIV_UNSIGNED_EN
    .op_unsigned(op_unsigned),
`endif
    .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t model(input logic o, input logic u,
                                 input logic [W-1:0] aa, input logic [W-1:0] bb);
    exp_t        e;
    logic [63:0] p, r;
    longint      sa, sbv;
    sa  = longint'($signed(aa));
    sbv = longint'($signed(bb));
    if (!o && bb == '0) begin
      e = '{m_hi, m_lo, 1'b1};
    end else if (o) begin
      if (u) p = {32'b0, aa} * {32'b0, bb};
      else   p = sa * sbv;
      e = '{p[63:32], p[31:0], 1'b0};
    end else begin
      if (u) begin
        p = {32'b0, aa / bb};
        r = {32'b0, aa % bb};
      end else begin
        p = sa / sbv;
        r = sa % sbv;
      end
      e = '{r[31:0], p[31:0], 1'b0};
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("div_zero", div_zero, e.dz);
      end
    end
  end

  // Called one time unit after a rising edge; returns at the same phase.
  task automatic run_op(input logic o, input logic u, input logic [W-1:0] aa,
                        input logic [W-1:0] bb, input bit repulse, input int rst_at);
    exp_t e;
    int   lat;
    bit   busy_bad, dz_case;
    dz_case = !o && bb == '0;
    op = o; a = aa; b = bb; start = 1'b1;
`ifdef MULDIV_UNSIGNED_EN
    op_unsigned = u;
`endif
    if (rst_at == 0) begin
      e = model(o, u, aa, bb);
      sb.push_back(e);
      m_hi = e.hi;
      m_lo = e.lo;
    end
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble the operands after acceptance; the result must not change.
    a = $urandom; b = $urandom; op = ~o;
`ifdef MULDIV_UNSIGNED_EN
    op_unsigned = ~u;
`endif
    lat = 0;
    busy_bad = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (busy !== (!dz_case && k <= W + 1)) busy_bad = 1'b1;
      if (rst_at == k) begin
        reset = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", div_zero, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("busy_before_rst", busy_bad, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        return;
      end
      if (done) begin
        lat = k;
        break;
      end
      start = repulse && (k + 1 == 5 || k + 1 == W + 2);
    end
    chk("latency", lat, dz_case ? 1 : W + 2);
    chk("busy_profile", busy_bad, 0);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    logic         ro, ru;
    logic [W-1:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
`ifdef MULDIV_UNSIGNED_EN
    op_unsigned = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dz", div_zero, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 1'b0, 0);  // 7 * -3
    run_op(1'b0, 1'b0, 32'hFFFFFFF9, 32'd2, 1'b0, 0);  // -7 / 2
    run_op(1'b0, 1'b0, 32'd5, 32'd0, 1'b0, 0);         // divide by zero
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 1'b1, 0);  // extra starts are ignored
    run_op(1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0);
    run_op(1'b1, 1'b0, 32'd3, 32'd4, 1'b0, 10);        // reset mid-operation
    run_op(1'b1, 1'b0, 32'd3, 32'd4, 1'b0, 0);
    run_op(1'b1, 1'b0, 32'h80000000, 32'h80000000, 1'b0, 0);
    run_op(1'b0, 1'b0, 32'd7, 32'hFFFFFFFE, 1'b0, 0);  // 7 / -2
`ifdef MULDIV_UNSIGNED_EN
    run_op(1'b0, 1'b1, 32'hFFFFFFFF, 32'd2, 1'b0, 0);
    run_op(1'b1, 1'b1, 32'hFFFFFFFF, 32'd2, 1'b0, 0);
`endif
    for (int i = 0; i < 30; i++) begin
      ro = 1'($urandom_range(0, 1));
      ru = 1'b0;
`ifdef MULDIV_UNSIGNED_EN
      ru = 1'($urandom_range(0, 1));
`endif
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = '0;
      else if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 30);
      run_op(ro, ru, ra, rb, 1'b0, 0);
    end
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
